// File: rtl/lut_ram_if.sv
// Bus bundle for lut_ram_core: one synchronous write port and one combinational read port.
interface lut_ram_if #(
    parameter int LUT_WIDTH = 32,
    parameter int LUT_DEPTH = 32
);
    localparam int ADDR_W = $clog2(LUT_DEPTH);

    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;
    logic [LUT_WIDTH-1:0] wr_data;
    logic [ADDR_W-1:0]    rd_addr;
    logic [LUT_WIDTH-1:0] rd_data;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output rd_addr,
        input  rd_data
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  rd_addr,
        output rd_data
    );
endinterface

// File: rtl/lut_ram_core.sv
// LUT-style RAM: synchronous write, asynchronous read, async active-high clear.
// Optional macro LUT_RAM_BYPASS_EN forwards same-address write data to the read port.
module lut_ram_core #(
    parameter int LUT_WIDTH = 32,
    parameter int LUT_DEPTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    lut_ram_if.slave bus
);
    localparam int ADDR_W = $clog2(LUT_DEPTH);
    // One extra bit so the range compare stays meaningful at power-of-two depths.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(LUT_DEPTH);

    logic [LUT_WIDTH-1:0] mem [LUT_DEPTH];
    logic                 wr_in_range;
    logic                 rd_in_range;
    logic                 wr_fire;
    logic [LUT_WIDTH-1:0] rd_word;

    assign wr_in_range = {1'b0, bus.wr_addr} < DEPTH_EXT;
    assign rd_in_range = {1'b0, bus.rd_addr} < DEPTH_EXT;
    assign wr_fire     = bus.wr_en && !rst && wr_in_range;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_fire) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Gating with rst keeps the port at zero during reset regardless of clear timing.
    always_comb begin
        rd_word = '0;
        if (!rst && rd_in_range) begin
            rd_word = mem[bus.rd_addr];
        end
`ifdef LUT_RAM_BYPASS_EN
        if (wr_fire && (bus.rd_addr == bus.wr_addr)) begin
            rd_word = bus.wr_data;
        end
`endif
    end

    assign bus.rd_data = rd_word;
endmodule

// File: tb/tb_lut_ram_core.sv
// Scoreboard bench for lut_ram_core: a 32-deep instance and a 1000-deep instance.
module tb_lut_ram_core;
    logic clk;
    logic rst;

    lut_ram_if #(.LUT_WIDTH(32), .LUT_DEPTH(32))   a_if ();
    lut_ram_if #(.LUT_WIDTH(32), .LUT_DEPTH(1000)) b_if ();

    lut_ram_core #(.LUT_WIDTH(32), .LUT_DEPTH(32)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    lut_ram_core #(.LUT_WIDTH(32), .LUT_DEPTH(1000)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        bit          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    event        smp;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_a [32];
    logic [31:0] ref_b [1000];

    // Monitor: samples the read port 1 time unit after each stimulus request.
    initial begin
        forever begin
            @(smp);
            #1;
            while (sb_q.size() > 0) begin
                exp_t        e;
                logic [31:0] act;
                e   = sb_q.pop_front();
                act = e.sel ? b_if.rd_data : a_if.rd_data;
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input bit sel, input int addr, input logic [31:0] exp, input string nm);
        if (sel) b_if.rd_addr = 10'(addr);
        else     a_if.rd_addr = 5'(addr);
        sb_q.push_back('{sel, exp, nm});
        ->smp;
        #2;
    endtask

    task automatic drive_a(input logic en, input int addr, input logic [31:0] data);
        a_if.wr_en   = en;
        a_if.wr_addr = 5'(addr);
        a_if.wr_data = data;
    endtask

    task automatic drive_b(input logic en, input int addr, input logic [31:0] data);
        b_if.wr_en   = en;
        b_if.wr_addr = 10'(addr);
        b_if.wr_data = data;
    endtask

    task automatic clear_models();
        for (int i = 0; i < 32; i++)   ref_a[i] = '0;
        for (int i = 0; i < 1000; i++) ref_b[i] = '0;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] same_pre;
        rst = 1'b0;
        drive_a(1'b0, 0, '0);
        drive_b(1'b0, 0, '0);
        a_if.rd_addr = '0;
        b_if.rd_addr = '0;
        #1 rst = 1'b1;
        clear_models();
        check(1'b0, 0, 32'h0, "reset_a0");
        check(1'b1, 999, 32'h0, "reset_b999");
        @(negedge clk);
        @(negedge clk);
        #3 rst = 1'b0;

        // Reset clear: write, then assert rst mid-cycle.
        @(negedge clk);
        drive_a(1'b1, 3, 32'hDEADBEEF);
        after_edge();
        drive_a(1'b0, 3, 32'h0);
        check(1'b0, 3, 32'hDEADBEEF, "pre_reset_a3");
        #2 rst = 1'b1;
        check(1'b0, 3, 32'h0, "async_reset_a3");
        #2 rst = 1'b0;
        check(1'b0, 3, 32'h0, "post_release_a3");
        after_edge();
        check(1'b0, 3, 32'h0, "stays_zero_a3");

        // Basic write/read.
        @(negedge clk);
        drive_a(1'b1, 5, 32'h12345678);
        check(1'b0, 5, 32'h0, "basic_pre_a5");
        after_edge();
        drive_a(1'b0, 5, 32'h0);
        check(1'b0, 5, 32'h12345678, "basic_post_a5");
        check(1'b0, 6, 32'h0, "untouched_a6");

        // Write-disable over several edges.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive_a(1'b0, 5, 32'hFFFFFFFF);
            after_edge();
            check(1'b0, 5, 32'h12345678, "wr_disable_a5");
        end

        // Same-cycle read/write.
        @(negedge clk);
        drive_a(1'b1, 7, 32'hAAAA0000);
        after_edge();
        @(negedge clk);
        drive_a(1'b1, 7, 32'h5555FFFF);
`ifdef LUT_RAM_BYPASS_EN
        same_pre = 32'h5555FFFF;
`else
        same_pre = 32'hAAAA0000;
`endif
        check(1'b0, 7, same_pre, "same_cycle_pre_a7");
        after_edge();
        check(1'b0, 7, 32'h5555FFFF, "same_cycle_post_a7");
        @(negedge clk);
        drive_a(1'b0, 0, 32'h0);

        // Non-power-of-two depth.
        @(negedge clk);
        drive_b(1'b1, 999, 32'hCAFEF00D);
        after_edge();
        check(1'b1, 999, 32'hCAFEF00D, "np2_b999");
        @(negedge clk);
        drive_b(1'b1, 1000, 32'h11111111);
        check(1'b1, 1000, 32'h0, "np2_pre_b1000");
        after_edge();
        check(1'b1, 1000, 32'h0, "np2_b1000");
        check(1'b1, 0, 32'h0, "np2_b0");
        check(1'b1, 999, 32'hCAFEF00D, "np2_b999_kept");
        @(negedge clk);
        drive_b(1'b0, 0, 32'h0);

        // Reset asserted while a write is pending discards it.
        @(negedge clk);
        drive_a(1'b1, 9, 32'h00000001);
        #4 rst = 1'b1;
        after_edge();
        check(1'b0, 9, 32'h0, "pending_wr_a9");
        check(1'b0, 5, 32'h0, "cleared_a5");
        @(negedge clk);
        drive_a(1'b0, 0, 32'h0);
        #3 rst = 1'b0;
        clear_models();

        // Randomised regression on the 32-deep instance.
        for (int n = 0; n < 1000; n++) begin
            logic        en;
            int          wa, ra;
            logic [31:0] wd, pre;
            @(negedge clk);
            en = 1'($urandom_range(0, 1));
            wa = int'($urandom_range(0, 31));
            ra = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 31));
            wd = $urandom;
            drive_a(en, wa, wd);
            pre = ref_a[ra];
`ifdef LUT_RAM_BYPASS_EN
            if (en && ra == wa) pre = wd;
`endif
            check(1'b0, ra, pre, "rand_a_pre");
            if (en) ref_a[wa] = wd;
            after_edge();
            check(1'b0, ra, ref_a[ra], "rand_a_post");
        end
        @(negedge clk);
        drive_a(1'b0, 0, 32'h0);

        // Randomised regression on the 1000-deep instance, including out-of-range addresses.
        for (int n = 0; n < 200; n++) begin
            logic        en;
            int          wa, ra;
            logic [31:0] wd, pre, post;
            @(negedge clk);
            en = 1'($urandom_range(0, 1));
            wa = int'($urandom_range(960, 1023));
            ra = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(960, 1023));
            wd = $urandom;
            drive_b(en, wa, wd);
            pre = (ra < 1000) ? ref_b[ra] : 32'h0;
`ifdef LUT_RAM_BYPASS_EN
            if (en && ra == wa && wa < 1000) pre = wd;
`endif
            check(1'b1, ra, pre, "rand_b_pre");
            if (en && wa < 1000) ref_b[wa] = wd;
            after_edge();
            post = (ra < 1000) ? ref_b[ra] : 32'h0;
            check(1'b1, ra, post, "rand_b_post");
        end
        @(negedge clk);
        drive_b(1'b0, 0, 32'h0);
        #5;

        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d expectations never sampled", sb_q.size());
        end
        if (checks < 12) begin
            errors++;
            $display("FAIL coverage: only %0d checks executed", checks);
        end
        if (errors != 0) begin
            $display("FAIL CHECKS %0d ERRORS %0d", checks, errors);
        end else begin
            $display("PASS CHECKS %0d ERRORS %0d", checks, errors);
        end
        $finish;
    end
endmodule

// File: doc/lut_ram_core.md
# lut_ram_core

Parameterised LUT-style RAM with one synchronous write port and one combinational (asynchronous) read port. It serves as small, fast storage inside the RV32I core, e.g. register-file-like tables, where a read must resolve within the same cycle. Contents are cleared by an asynchronous active-high reset. Address decoding tolerates non-power-of-two depths.

## Interface
- LUT_WIDTH, default 32 (XLEN): data word width in bits, ≥1.
- LUT_DEPTH, default 32: number of words, ≥2; need not be a power of two.
- ADDR_W (localparam) = $clog2(LUT_DEPTH): address width.

- clk  in  1  write clock, rising-edge.
- rst  in  1  reset; asynchronous and active-high.
- wr_en  in  1  write enable, sampled at the rising edge of clk.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  LUT_WIDTH  write data.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  LUT_WIDTH  read data; combinational function of rd_addr and storage.

## Operation
- Storage is LUT_DEPTH words of LUT_WIDTH bits, indexed 0..LUT_DEPTH-1.
- Write: at a rising edge of clk with rst low and wr_en=1, mem[wr_addr] ← wr_data. With wr_en=0, no entry changes.
- Read: rd_data = mem[rd_addr] at all times. No clock and no enable are involved.
- Out-of-range addresses (≥ LUT_DEPTH, possible when the depth is not a power of two):
  - Writes are ignored, with no aliasing and no wrap.
  - Reads return all zeros.
- Reset: while rst is high, every entry is forced to 0 and rd_data reads 0 for any address. Writes are blocked while rst is high.
- There are no X outputs after reset. Before the first reset, contents are undefined.

## Timing
- Read latency: 0 cycles, purely combinational from rd_addr and memory to rd_data.
- Write latency: 1 edge. Data written at edge N is visible on rd_data immediately after edge N, within the same delta/propagation.
- Same-cycle read and write to the same address (rd_addr == wr_addr, wr_en=1, before the edge): rd_data shows the OLD contents until the edge, then the new value. This read-before-write default is changed only by the configuration macro.
- Reset assertion takes effect immediately, without waiting for a clock edge.
- Reset deassertion is synchronised by the surrounding design. An edge coincident with rst falling performs no write.
- Reset asserted mid-sequence discards any write pending for that edge.

## Configuration
- LUT_RAM_BYPASS_EN:
  - Defined: combinational write-through. When wr_en=1, rst=0 and rd_addr == wr_addr (in range), rd_data = wr_data before the edge. All other reads are unchanged.
  - Undefined (default): read-before-write as described in Timing, with no forwarding path.

## Test plan
- Reset clear: write 0xDEADBEEF to addr 3, assert rst asynchronously mid-cycle → rd_data at addr 3 reads 0x00000000 immediately. It stays 0 after rst releases until it is written again.
- Basic write/read: write 0x12345678 to addr 5 at edge N. rd_addr=5 → 0x12345678 just after edge N. Addr 6 is untouched and reads 0.
- Write-disable: wr_en=0, wr_addr=5, wr_data=0xFFFFFFFF over several edges → addr 5 still reads 0x12345678.
- Same-cycle read/write: addr 7 holds 0xAAAA0000; drive wr_en=1, wr_addr=rd_addr=7, wr_data=0x5555FFFF.
  - Without LUT_RAM_BYPASS_EN: 0xAAAA0000 before the edge, 0x5555FFFF after it.
  - With LUT_RAM_BYPASS_EN: 0x5555FFFF before the edge.
- Non-power-of-two depth (LUT_DEPTH=1000): write 0xCAFEF00D to addr 999 → reads back. Write 0x11111111 to addr 1000 → addr 1000 reads 0, and addr 0 and addr 999 are unchanged.
- Randomised regression: 1000 random transactions compared against a behavioural reference model, sampling both before and after each edge → zero mismatches.
